// File: rtl/uart_csr_master.sv
// Serial-to-CSR bridge: decodes read/write frames from a byte stream and drives the CSR bus.
// Read data or a write acknowledge is returned as bytes to the transmitter.
module uart_csr_master #(
  parameter int unsigned timeout_cycles = 1000000,
  parameter logic [7:0]  ack_byte       = 8'hAA
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic [7:0]  tx_data,
  output logic        tx_wr,
  input  logic        tx_done,
  output logic [13:0] csr_a,
  output logic        csr_we,
  output logic [31:0] csr_di,
  input  logic [31:0] csr_do,
  output logic        busy,
  output logic        frame_err
);

  localparam int unsigned   TmoW    = $clog2(timeout_cycles);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(timeout_cycles - 1);

  typedef enum logic [3:0] {
    StIdle, StAddrHi, StAddrLo, StData, StCsrWr, StCsrRd, StCsrCap, StTxSend, StTxWait
  } state_e;

  state_e          state_q, state_d;
  logic            is_wr_q, is_wr_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [13:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [13:0]     csr_a_q, csr_a_d;
  logic [31:0]     csr_di_q, csr_di_d;
  logic [31:0]     resp_q, resp_d;
  logic            ferr_q, ferr_d;
  logic            timed;

  assign timed = (state_q == StAddrHi) || (state_q == StAddrLo) || (state_q == StData);

  always_comb begin
    state_d  = state_q;
    is_wr_d  = is_wr_q;
    cnt_d    = cnt_q;
    tmo_d    = '0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    csr_a_d  = csr_a_q;
    csr_di_d = csr_di_q;
    resp_d   = resp_q;
    ferr_d   = 1'b0;

    case (state_q)
      StIdle: begin
        if (rx_done) begin
          if (rx_data == 8'h01 || rx_data == 8'h02) begin
            is_wr_d = (rx_data == 8'h02);
            state_d = StAddrHi;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      StAddrHi: begin
        if (rx_done) begin
          addr_d[13:8] = rx_data[5:0];
          state_d      = StAddrLo;
        end
      end
      StAddrLo: begin
        if (rx_done) begin
          addr_d[7:0] = rx_data;
          if (is_wr_q) begin
            cnt_d   = 3'd0;
            state_d = StData;
          end else begin
            csr_a_d = {addr_q[13:8], rx_data};
            state_d = StCsrRd;
          end
        end
      end
      StData: begin
        if (rx_done) begin
          wdata_d = {wdata_q[23:0], rx_data};
          if (cnt_q == 3'd3) begin
            // Commit address and data together so an aborted frame leaves the bus untouched.
            csr_a_d  = addr_q;
            csr_di_d = {wdata_q[23:0], rx_data};
            state_d  = StCsrWr;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      StCsrWr: begin
        resp_d  = {ack_byte, 24'h000000};
        cnt_d   = 3'd1;
        state_d = StTxSend;
      end
      StCsrRd:  state_d = StCsrCap;
      StCsrCap: begin
        resp_d  = csr_do;
        cnt_d   = 3'd4;
        state_d = StTxSend;
      end
      StTxSend: state_d = StTxWait;
      StTxWait: begin
        if (tx_done) begin
          cnt_d   = cnt_q - 3'd1;
          resp_d  = {resp_q[23:0], 8'h00};
          state_d = (cnt_q == 3'd1) ? StIdle : StTxSend;
        end
      end
      default: state_d = StIdle;
    endcase

    // A byte arriving on the expiry cycle wins over the timeout.
    if (timed && !rx_done) begin
      if (tmo_q == TmoLast) begin
        state_d = StIdle;
        ferr_d  = 1'b1;
      end else begin
        tmo_d = tmo_q + TmoW'(1);
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q  <= StIdle;
      is_wr_q  <= 1'b0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      csr_a_q  <= '0;
      csr_di_q <= '0;
      resp_q   <= '0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_wr_q  <= is_wr_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      csr_a_q  <= csr_a_d;
      csr_di_q <= csr_di_d;
      resp_q   <= resp_d;
      ferr_q   <= ferr_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign csr_we    = (state_q == StCsrWr);
  assign tx_wr     = (state_q == StTxSend);
  assign tx_data   = resp_q[31:24];
  assign csr_a     = csr_a_q;
  assign csr_di    = csr_di_q;
  assign frame_err = ferr_q;

endmodule
